// File: rtl/csr_bank_arbiter.sv
// Round-robin arbiter that serialises host word accesses and core bit accesses onto one CSR bank.
// Optional macro CSR_ARB_HOST_RO_MASK_EN adds a per-CSR host write-protect mask and host_err.
module csr_bank_arbiter #(
  parameter  int WIDTH    = 32,
  parameter  int NUM_REGS = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int BIT_W    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [WIDTH-1:0]  host_wdata,
  output logic              host_ack,
  output logic [WIDTH-1:0]  host_rdata,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [BIT_W-1:0]  core_bit_addr,
  input  logic              core_bit_data,
  output logic              core_ack,
  output logic              core_rbit,
  output logic [ADDR_W-1:0] csr_sel,
  output logic              csr_load_all_n,
  output logic              csr_load_bit_n,
  output logic [WIDTH-1:0]  csr_d_all,
  output logic              csr_d_bit,
  output logic [BIT_W-1:0]  csr_bit_addr,
  input  logic [WIDTH-1:0]  csr_q_all,
  input  logic              csr_q_bit,
`ifdef CSR_ARB_HOST_RO_MASK_EN
  input  logic [NUM_REGS-1:0] host_ro_mask,
  output logic                host_err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_HOST, OWN_CORE} owner_e;

  state_e state, state_next;
  owner_e owner, last_grant;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [WIDTH-1:0]  lat_wdata;
  logic [BIT_W-1:0]  lat_bit_addr;
  logic              lat_bit_data;
  logic              lat_ro;
  logic              grant_host, grant_core, in_range, ro_hit;

  always_comb begin
    grant_host = host_req && (!core_req || last_grant == OWN_CORE);
    grant_core = core_req && !grant_host;
  end

  // Widened compare keeps the check meaningful for both power-of-2 and partial banks.
  assign in_range = {1'b0, lat_addr} < (ADDR_W+1)'(NUM_REGS);

`ifdef CSR_ARB_HOST_RO_MASK_EN
  always_comb begin
    ro_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (host_addr == ADDR_W'(i)) ro_hit = host_ro_mask[i];
    end
  end
`else
  assign ro_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_host || grant_core) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWN_CORE;
      last_grant   <= OWN_CORE;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_bit_addr <= '0;
      lat_bit_data <= 1'b0;
      lat_ro       <= 1'b0;
      host_rdata   <= '0;
      core_rbit    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (grant_host) begin
          owner      <= OWN_HOST;
          last_grant <= OWN_HOST;
          lat_we     <= host_we;
          lat_addr   <= host_addr;
          lat_wdata  <= host_wdata;
          lat_ro     <= ro_hit;
        end else if (grant_core) begin
          owner        <= OWN_CORE;
          last_grant   <= OWN_CORE;
          lat_we       <= core_we;
          lat_addr     <= core_addr;
          lat_bit_addr <= core_bit_addr;
          lat_bit_data <= core_bit_data;
          lat_ro       <= 1'b0;
        end
      end
      if (state == ACCESS && !lat_we) begin
        if (owner == OWN_HOST) host_rdata <= in_range ? csr_q_all : '0;
        else                   core_rbit  <= in_range && csr_q_bit;
      end
    end
  end

  always_comb begin
    host_ack       = 1'b0;
    core_ack       = 1'b0;
    csr_load_all_n = 1'b1;
    csr_load_bit_n = 1'b1;
    busy           = (state != IDLE);
`ifdef CSR_ARB_HOST_RO_MASK_EN
    host_err       = 1'b0;
`endif
    case (state)
      ACCESS: begin
        if (lat_we && in_range) begin
          if (owner == OWN_HOST) csr_load_all_n = lat_ro;
          else                   csr_load_bit_n = 1'b0;
        end
      end
      DONE: begin
        host_ack = (owner == OWN_HOST);
        core_ack = (owner == OWN_CORE);
`ifdef CSR_ARB_HOST_RO_MASK_EN
        host_err = (owner == OWN_HOST) && lat_we && lat_ro;
`endif
      end
      default: ;
    endcase
  end

  assign csr_sel      = lat_addr;
  assign csr_d_all    = lat_wdata;
  assign csr_d_bit    = lat_bit_data;
  assign csr_bit_addr = lat_bit_addr;

endmodule

// File: tb/tb_csr_bank_arbiter.sv
// Directed bench: instance a uses the default 8-CSR bank, instance b a 5-CSR bank, same inputs.
module tb_csr_bank_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, host_req, host_we, core_req, core_we, core_bit_data;
  logic [2:0]  host_addr, core_addr;
  logic [31:0] host_wdata;
  logic [4:0]  core_bit_addr;

  logic        a_host_ack, a_core_ack, a_core_rbit, a_load_all_n, a_load_bit_n, a_d_bit, a_q_bit, a_busy;
  logic [31:0] a_host_rdata, a_d_all, a_q_all;
  logic [2:0]  a_sel;
  logic [4:0]  a_bit_addr;
  logic        b_host_ack, b_core_ack, b_core_rbit, b_load_all_n, b_load_bit_n, b_d_bit, b_q_bit, b_busy;
  logic [31:0] b_host_rdata, b_d_all, b_q_all;
  logic [2:0]  b_sel;
  logic [4:0]  b_bit_addr;
`ifdef CSR_ARB_HOST_RO_MASK_EN
  logic [7:0]  mask_a;
  logic [4:0]  mask_b;
  logic        a_err, b_err;
`endif

  int errors, checks;

  csr_bank_arbiter #(.WIDTH(32), .NUM_REGS(8)) u_a (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(a_host_ack), .host_rdata(a_host_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_bit_addr(core_bit_addr), .core_bit_data(core_bit_data),
    .core_ack(a_core_ack), .core_rbit(a_core_rbit),
    .csr_sel(a_sel), .csr_load_all_n(a_load_all_n), .csr_load_bit_n(a_load_bit_n),
    .csr_d_all(a_d_all), .csr_d_bit(a_d_bit), .csr_bit_addr(a_bit_addr),
    .csr_q_all(a_q_all), .csr_q_bit(a_q_bit),
`ifdef CSR_ARB_HOST_RO_MASK_EN
    .host_ro_mask(mask_a), .host_err(a_err),
`endif
    .busy(a_busy)
  );

  csr_bank_arbiter #(.WIDTH(32), .NUM_REGS(5)) u_b (
    .clk(clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(b_host_ack), .host_rdata(b_host_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_bit_addr(core_bit_addr), .core_bit_data(core_bit_data),
    .core_ack(b_core_ack), .core_rbit(b_core_rbit),
    .csr_sel(b_sel), .csr_load_all_n(b_load_all_n), .csr_load_bit_n(b_load_bit_n),
    .csr_d_all(b_d_all), .csr_d_bit(b_d_bit), .csr_bit_addr(b_bit_addr),
    .csr_q_all(b_q_all), .csr_q_bit(b_q_bit),
`ifdef CSR_ARB_HOST_RO_MASK_EN
    .host_ro_mask(mask_b), .host_err(b_err),
`endif
    .busy(b_busy)
  );

  // Bank models; bank b holds a nonzero word beyond its last CSR so unmasked reads would show.
  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];
  assign a_q_all = mem_a[a_sel];
  assign a_q_bit = mem_a[a_sel][a_bit_addr];
  assign b_q_all = mem_b[b_sel];
  assign b_q_bit = mem_b[b_sel][b_bit_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= (i == 6) ? 32'hA5A5_A5A5 : 32'h0;
      end
    end else begin
      if (!a_load_all_n) mem_a[a_sel] <= a_d_all;
      if (!a_load_bit_n) mem_a[a_sel][a_bit_addr] <= a_d_bit;
      if (!b_load_all_n) mem_b[b_sel] <= b_d_all;
      if (!b_load_bit_n) mem_b[b_sel][b_bit_addr] <= b_d_bit;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    core_req = 0; core_we = 0; core_addr = 0; core_bit_addr = 0; core_bit_data = 0;
`ifdef CSR_ARB_HOST_RO_MASK_EN
    mask_a = '0; mask_b = '0;
`endif
    tick(); tick();
    chk("rst_busy", {31'b0, a_busy}, 0);
    chk("rst_host_ack", {31'b0, a_host_ack}, 0);
    chk("rst_core_ack", {31'b0, a_core_ack}, 0);
    chk("rst_load_all_n", {31'b0, a_load_all_n}, 1);
    chk("rst_load_bit_n", {31'b0, a_load_bit_n}, 1);
    chk("rst_sel", {29'b0, a_sel}, 0);
    chk("rst_rdata", a_host_rdata, 0);
    chk("rst_rbit", {31'b0, a_core_rbit}, 0);
    chk("rst_d_all", a_d_all, 0);
`ifdef CSR_ARB_HOST_RO_MASK_EN
    chk("rst_err", {31'b0, a_err}, 0);
`endif
    reset = 1'b0;

    // host word write
    host_req = 1; host_we = 1; host_addr = 3; host_wdata = 32'hDEAD_BEEF;
    tick();
    chk("hw_strobe", {31'b0, a_load_all_n}, 0);
    chk("hw_sel", {29'b0, a_sel}, 3);
    chk("hw_d_all", a_d_all, 32'hDEAD_BEEF);
    chk("hw_bit_n", {31'b0, a_load_bit_n}, 1);
    chk("hw_busy", {31'b0, a_busy}, 1);
    chk("hw_early_ack", {31'b0, a_host_ack}, 0);
    tick();
    chk("hw_strobe_off", {31'b0, a_load_all_n}, 1);
    chk("hw_ack", {31'b0, a_host_ack}, 1);
    chk("hw_core_ack", {31'b0, a_core_ack}, 0);
    host_req = 0;
    tick();
    chk("hw_ack_pulse", {31'b0, a_host_ack}, 0);
    chk("hw_idle", {31'b0, a_busy}, 0);

    // host read; inputs changed after grant must be ignored
    host_req = 1; host_we = 0;
    tick();
    host_addr = 7; host_we = 1;
    chk("hr_no_strobe", {31'b0, a_load_all_n}, 1);
    chk("hr_sel_latched", {29'b0, a_sel}, 3);
    tick();
    chk("hr_ack", {31'b0, a_host_ack}, 1);
    chk("hr_rdata", a_host_rdata, 32'hDEAD_BEEF);
    host_req = 0; host_we = 0;
    tick();
    chk("hr_rdata_held", a_host_rdata, 32'hDEAD_BEEF);

    // core bit write then reads
    core_req = 1; core_we = 1; core_addr = 2; core_bit_addr = 5; core_bit_data = 1;
    tick();
    chk("cw_strobe", {31'b0, a_load_bit_n}, 0);
    chk("cw_all_n", {31'b0, a_load_all_n}, 1);
    chk("cw_bit_addr", {27'b0, a_bit_addr}, 5);
    chk("cw_d_bit", {31'b0, a_d_bit}, 1);
    chk("cw_sel", {29'b0, a_sel}, 2);
    tick();
    chk("cw_ack", {31'b0, a_core_ack}, 1);
    chk("cw_host_ack", {31'b0, a_host_ack}, 0);
    core_req = 0;
    tick();
    core_req = 1; core_we = 0;
    tick();
    chk("cr_no_strobe", {31'b0, a_load_bit_n}, 1);
    tick();
    chk("cr_ack", {31'b0, a_core_ack}, 1);
    chk("cr_rbit5", {31'b0, a_core_rbit}, 1);
    core_req = 0;
    tick();
    core_bit_addr = 4; core_req = 1;
    tick(); tick();
    chk("cr_rbit4", {31'b0, a_core_rbit}, 0);
    core_req = 0;
    tick();

    // reset during ACCESS of a host write
    host_req = 1; host_we = 1; host_addr = 5; host_wdata = 32'h55;
    tick();
    chk("ra_strobe", {31'b0, a_load_all_n}, 0);
    reset = 1;
    tick();
    chk("ra_busy", {31'b0, a_busy}, 0);
    chk("ra_all_n", {31'b0, a_load_all_n}, 1);
    chk("ra_bit_n", {31'b0, a_load_bit_n}, 1);
    chk("ra_no_ack", {31'b0, a_host_ack}, 0);
    chk("ra_sel", {29'b0, a_sel}, 0);
    reset = 0;
    tick();
    chk("ra_retry_strobe", {31'b0, a_load_all_n}, 0);
    chk("ra_retry_sel", {29'b0, a_sel}, 5);
    tick();
    chk("ra_retry_ack", {31'b0, a_host_ack}, 1);
    host_req = 0;
    tick();

    // round-robin right after reset: host first, then alternating
    reset = 1;
    tick();
    reset = 0;
    host_req = 1; host_we = 1; host_addr = 0; host_wdata = 32'h1111_1111;
    core_req = 1; core_we = 1; core_addr = 4; core_bit_addr = 0; core_bit_data = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_all_n", {31'b0, a_load_all_n}, (k % 2 == 0) ? 0 : 1);
      chk("rr_bit_n", {31'b0, a_load_bit_n}, (k % 2 == 0) ? 1 : 0);
      tick();
      chk("rr_host_ack", {31'b0, a_host_ack}, (k % 2 == 0) ? 1 : 0);
      chk("rr_core_ack", {31'b0, a_core_ack}, (k % 2 == 0) ? 0 : 1);
      tick();
      chk("rr_idle", {31'b0, a_busy}, 0);
    end
    host_req = 0; core_req = 0;
    tick();

    // addresses beyond a 5-CSR bank
    host_req = 1; host_we = 1; host_addr = 6; host_wdata = 32'h1234_5678;
    tick();
    chk("oor_b_no_strobe", {31'b0, b_load_all_n}, 1);
    chk("oor_a_strobe", {31'b0, a_load_all_n}, 0);
    tick();
    chk("oor_b_ack", {31'b0, b_host_ack}, 1);
    host_req = 0;
    tick();
    host_req = 1; host_we = 0;
    tick(); tick();
    chk("oor_b_rdata", b_host_rdata, 0);
    chk("oor_a_rdata", a_host_rdata, 32'h1234_5678);
    host_req = 0;
    tick();
    core_req = 1; core_we = 0; core_addr = 6; core_bit_addr = 5;
    tick(); tick();
    chk("oor_b_rbit", {31'b0, b_core_rbit}, 0);
    chk("oor_a_rbit", {31'b0, a_core_rbit}, 1);
    core_req = 0;
    tick();
    core_req = 1; core_we = 1; core_bit_data = 0;
    tick();
    chk("oor_b_no_bit_strobe", {31'b0, b_load_bit_n}, 1);
    tick();
    chk("oor_b_core_ack", {31'b0, b_core_ack}, 1);
    core_req = 0;
    tick();

`ifdef CSR_ARB_HOST_RO_MASK_EN
    mask_a = 8'b0000_0010; mask_b = 5'b00010;
    host_req = 1; host_we = 1; host_addr = 1; host_wdata = 32'hFFFF_FFFF;
    tick();
    chk("ro_no_strobe", {31'b0, a_load_all_n}, 1);
    chk("ro_err_early", {31'b0, a_err}, 0);
    tick();
    chk("ro_ack", {31'b0, a_host_ack}, 1);
    chk("ro_err", {31'b0, a_err}, 1);
    chk("ro_err_b", {31'b0, b_err}, 1);
    host_req = 0;
    tick();
    chk("ro_err_pulse", {31'b0, a_err}, 0);
    core_req = 1; core_we = 1; core_addr = 1; core_bit_addr = 0; core_bit_data = 1;
    tick();
    chk("ro_core_strobe", {31'b0, a_load_bit_n}, 0);
    tick();
    chk("ro_core_ack", {31'b0, a_core_ack}, 1);
    chk("ro_core_no_err", {31'b0, a_err}, 0);
    core_req = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_bank_arbiter.md
Name: csr_bank_arbiter

Overview:
- Controller that shares one bank of bit-addressable CSRs between two requesters.
- Requesters: the host bus (HPS-side word reads and writes) and the GPU core (single-bit status set, clear and read).
- The block serialises all accesses and drives the bank's shared write strobes, which are active-low.
- It also samples the bank's muxed read data, so the bank never sees two accesses in the same cycle.

Parameters:
- WIDTH, 32, data width of each CSR.
- NUM_REGS, 8, number of CSRs in the bank.
- Derived (localparam): ADDR_W = $clog2(NUM_REGS); BIT_W = $clog2(WIDTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- host_req  in  1  host access request; held high until host_ack.
- host_we  in  1  1 = write whole word, 0 = read word.
- host_addr  in  ADDR_W  CSR index.
- host_wdata  in  WIDTH  write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  WIDTH  read data; valid while host_ack = 1, held until next host read.
- core_req  in  1  core access request; held high until core_ack.
- core_we  in  1  1 = write single bit, 0 = read single bit.
- core_addr  in  ADDR_W  CSR index.
- core_bit_addr  in  BIT_W  bit index within the CSR.
- core_bit_data  in  1  bit value to write.
- core_ack  out  1  one-cycle completion pulse.
- core_rbit  out  1  read bit; valid while core_ack = 1, held until next core read.
- csr_sel  out  ADDR_W  selected CSR index for bank decode.
- csr_load_all_n  out  1  active-low word-load strobe to the selected CSR.
- csr_load_bit_n  out  1  active-low bit-load strobe to the selected CSR.
- csr_d_all  out  WIDTH  word write data.
- csr_d_bit  out  1  bit write data.
- csr_bit_addr  out  BIT_W  bit index.
- csr_q_all  in  WIDTH  selected CSR contents (combinational from bank).
- csr_q_bit  in  1  selected CSR bit (combinational from bank).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - host_ack = core_ack = 0; busy = 0.
  - host_rdata = 0; core_rbit = 0.
  - csr_load_all_n = csr_load_bit_n = 1.
  - csr_sel, csr_d_all, csr_d_bit, csr_bit_addr = 0.
  - last_grant = CORE, so the host wins the first tie.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the one that is not last_grant (round-robin).
  - On grant, latch that requester's addr, we, data and bit_addr into internal registers, update last_grant, and go to ACCESS.
- ACCESS (exactly one cycle):
  - Drive csr_sel and the data lines from the latched values.
  - Host write: csr_load_all_n = 0.
  - Core write: csr_load_bit_n = 0.
  - Reads: both strobes stay 1; at the end of the cycle capture csr_q_all into host_rdata, or csr_q_bit into core_rbit.
  - Never assert both strobes low together.
- DONE: pulse the granted requester's ack for one cycle, then return to IDLE.
- Latency: 3 cycles from req sampled in IDLE to ack; throughput is one access per 3 cycles.
- A requester that keeps req high after its ack is treated as a new request in the next IDLE. The other pending requester wins that arbitration.
- Input changes after grant are ignored, because all inputs are latched.
- req dropped before ack: the access still completes and the ack is still pulsed. The requester is responsible for holding req; this is not an error.
- Address >= NUM_REGS (non-power-of-2 bank):
  - Write: no strobe, but ack still given.
  - Read: returns 0.
- Reset asserted in any state: returns to IDLE next edge with all outputs at reset values. An in-flight access is abandoned with no ack.
- A strobe that was low in the reset cycle is deasserted at that edge.

Optional Feature:
- Macro: CSR_ARB_HOST_RO_MASK_EN.
- Defined:
  - Adds input host_ro_mask [NUM_REGS-1:0] and output host_err (1 bit, reset 0).
  - A host write to a CSR whose mask bit is 1 drives no strobe. That access still completes with host_ack, and host_err = 1 for the ack cycle only.
  - Core accesses are unaffected by the mask.
- Undefined: neither port exists and all CSRs are host-writable.

Test Plan:
- Reset, then host write 0xDEADBEEF to addr 3 -> csr_load_all_n low for exactly 1 cycle with csr_sel = 3, then host_ack 1 cycle later. A following host read of addr 3 returns host_rdata = 0xDEADBEEF.
- Core bit write: addr 2, bit 5, data 1 -> csr_load_bit_n low for 1 cycle, csr_bit_addr = 5, csr_d_bit = 1, csr_load_all_n stays 1. A core read of the same bit returns core_rbit = 1.
- host_req and core_req rise in the same cycle after reset -> host granted first. Both held high -> grants alternate host, core, host, core over 4 accesses.
- Reset asserted during ACCESS of a host write -> no ack; busy = 0 and both strobes = 1 on the next cycle; the next request is served normally.
- NUM_REGS = 5, host write to addr 6 -> no strobe, host_ack pulses; a host read of addr 6 returns 0.
- With CSR_ARB_HOST_RO_MASK_EN and host_ro_mask = 8'b0000_0010, host write to addr 1 -> no strobe, host_ack and host_err both 1 for one cycle. Core bit write to addr 1 succeeds.
